// File: rtl/battleship_input_conditioner.sv
// Battleship control front end: synchronizes, debounces and edge-detects the six player controls.
// Emits registered one-cycle press pulses (moves arbitrated to one-hot) and debounced held levels.
module battleship_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       izquierda_n,
   input  logic       derecha_n,
   input  logic       arriba_n,
   input  logic       abajo_n,
   input  logic       attack_raw,
   input  logic       poner_raw,
   output logic [3:0] move_pulse,
   output logic       attack_pulse,
   output logic       poner_pulse,
   output logic [5:0] held
);

   localparam int unsigned NCH   = 6;
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Idle level of each raw input: direction buttons rest high, attack/poner rest low
   localparam logic [NCH-1:0] RELEASED_LVL = 6'b00_1111;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   logic [NCH-1:0]                  w_raw;
   logic [SYNC_STAGES-1:0][NCH-1:0] r_sync;
   logic [NCH-1:0]                  w_pressed;
   logic [NCH-1:0]                  w_press;
   logic [3:0]                      w_move_sel;
   logic [3:0]                      r_move_pulse;
   logic                            r_attack_pulse;
   logic                            r_poner_pulse;

   assign w_raw = {poner_raw, attack_raw, abajo_n, arriba_n, derecha_n, izquierda_n};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= {SYNC_STAGES{RELEASED_LVL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
      end
   end

   assign w_pressed = r_sync[SYNC_STAGES-1] ^ RELEASED_LVL;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      state_t           r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_held;

      // Press qualifies on the cycle the counter expires in PRESS_WAIT; the pulse is registered
      // at the same edge that moves the FSM into HELD, so pulse and held rise together.
      assign w_press[g] = (r_state == PRESS_WAIT) && w_pressed[g] && (r_cnt == CNT_LAST);
      assign held[g]    = r_held;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (w_pressed[g]) begin
                     r_state <= PRESS_WAIT;
                     r_cnt   <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!w_pressed[g]) begin
                     r_state <= IDLE;
                  end else if (r_cnt == CNT_LAST) begin
                     r_state <= HELD;
                     r_held  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               HELD: begin
                  if (!w_pressed[g]) begin
                     r_state <= RELEASE_WAIT;
                     r_cnt   <= '0;
                  end
               end
               RELEASE_WAIT: begin
                  if (w_pressed[g]) begin
                     r_state <= HELD;
                  end else if (r_cnt == CNT_LAST) begin
                     r_state <= IDLE;
                     r_held  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_held  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Fixed priority izquierda > derecha > arriba > abajo; losers are dropped
   always_comb begin
      w_move_sel = '0;
      if (w_press[0]) begin
         w_move_sel = 4'b0001;
      end else if (w_press[1]) begin
         w_move_sel = 4'b0010;
      end else if (w_press[2]) begin
         w_move_sel = 4'b0100;
      end else if (w_press[3]) begin
         w_move_sel = 4'b1000;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_move_pulse   <= '0;
         r_attack_pulse <= 1'b0;
         r_poner_pulse  <= 1'b0;
      end else begin
         r_move_pulse   <= w_move_sel;
         r_attack_pulse <= w_press[4];
         r_poner_pulse  <= w_press[5];
      end
   end

   assign move_pulse   = r_move_pulse;
   assign attack_pulse = r_attack_pulse;
   assign poner_pulse  = r_poner_pulse;

endmodule

// File: tb/tb_battleship_input_conditioner.sv
// Directed bench for battleship_input_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Stimulus pushes expected pulse events; a negedge monitor pops and compares each observed pulse.
module tb_battleship_input_conditioner;

   localparam int unsigned LAT = 7;

   logic       clk;
   logic       reset;
   logic       izquierda_n;
   logic       derecha_n;
   logic       arriba_n;
   logic       abajo_n;
   logic       attack_raw;
   logic       poner_raw;
   logic [3:0] move_pulse;
   logic       attack_pulse;
   logic       poner_pulse;
   logic [5:0] held;

   int unsigned cyc;
   int          vectors;
   int          miscompares;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  mv;
      logic        at;
      logic        po;
      logic [5:0]  hd;
   } exp_t;

   exp_t sb[$];

   battleship_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .SYNC_STAGES    (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .izquierda_n (izquierda_n),
      .derecha_n   (derecha_n),
      .arriba_n    (arriba_n),
      .abajo_n     (abajo_n),
      .attack_raw  (attack_raw),
      .poner_raw   (poner_raw),
      .move_pulse  (move_pulse),
      .attack_pulse(attack_pulse),
      .poner_pulse (poner_pulse),
      .held        (held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic expect_pulse(input int unsigned at_cyc, input logic [3:0] mv, input logic at,
                               input logic po, input logic [5:0] hd);
      exp_t e;
      e.cyc = at_cyc;
      e.mv  = mv;
      e.at  = at;
      e.po  = po;
      e.hd  = hd;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (move_pulse != 4'b0000 || attack_pulse || poner_pulse) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pulse cyc=%0d got move=%b att=%b pon=%b expected no pulse",
                     cyc, move_pulse, attack_pulse, poner_pulse);
         end else begin
            e = sb.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_value", {20'd0, move_pulse, attack_pulse, poner_pulse, held},
                {20'd0, e.mv, e.at, e.po, e.hd});
         end
      end
   end

   initial begin
      int unsigned c;
      exp_t e;
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      izquierda_n = 1'b1;
      derecha_n   = 1'b1;
      arriba_n    = 1'b1;
      abajo_n     = 1'b1;
      attack_raw  = 1'b0;
      poner_raw   = 1'b0;

      @(negedge clk);
      chk("rst_move", {28'd0, move_pulse}, 32'd0);
      chk("rst_attack", {31'd0, attack_pulse}, 32'd0);
      chk("rst_poner", {31'd0, poner_pulse}, 32'd0);
      chk("rst_held", {26'd0, held}, 32'd0);
      step(2);
      reset = 1'b0;
      step(4);

      // 1: clean derecha press
      derecha_n = 1'b0;
      c = cyc;
      expect_pulse(c + LAT, 4'b0010, 1'b0, 1'b0, 6'b000010);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cyc == c + LAT - 1) chk("t1_held_before", {26'd0, held}, 32'd0);
         if (cyc == c + LAT + 1) chk("t1_held_after", {26'd0, held}, 32'd2);
         step(1);
      end
      derecha_n = 1'b1;
      step(15);
      @(negedge clk);
      chk("t1_released", {26'd0, held}, 32'd0);
      step(1);

      // 2: bouncing derecha never qualifies
      for (int i = 0; i < 14; i++) begin
         derecha_n = (i < 2 || i == 3 || i == 4) ? 1'b0 : 1'b1;
         @(negedge clk);
         chk("t2_held", {26'd0, held}, 32'd0);
         step(1);
      end

      // 3: attack held with a short release glitch
      attack_raw = 1'b1;
      c = cyc;
      expect_pulse(c + LAT, 4'b0000, 1'b1, 1'b0, 6'b010000);
      for (int i = 0; i < 32; i++) begin
         attack_raw = (i >= 20 && i < 22) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (cyc >= c + LAT) chk("t3_held4", {31'd0, held[4]}, 32'd1);
         step(1);
      end
      attack_raw = 1'b0;
      step(15);
      @(negedge clk);
      chk("t3_released", {26'd0, held}, 32'd0);
      step(1);

      // 4: izquierda and abajo together, izquierda wins
      izquierda_n = 1'b0;
      abajo_n     = 1'b0;
      c = cyc;
      expect_pulse(c + LAT, 4'b0001, 1'b0, 1'b0, 6'b001001);
      step(12);
      @(negedge clk);
      chk("t4_held", {26'd0, held}, 32'd9);
      step(1);
      izquierda_n = 1'b1;
      abajo_n     = 1'b1;
      step(15);

      // 5: poner, attack and arriba coincide
      poner_raw  = 1'b1;
      attack_raw = 1'b1;
      arriba_n   = 1'b0;
      c = cyc;
      expect_pulse(c + LAT, 4'b0100, 1'b1, 1'b1, 6'b110100);
      step(12);
      @(negedge clk);
      chk("t5_held", {26'd0, held}, 32'h34);
      step(1);
      poner_raw  = 1'b0;
      attack_raw = 1'b0;
      arriba_n   = 1'b1;
      step(15);

      // 6: reset during a derecha debounce while poner is held
      poner_raw = 1'b1;
      c = cyc;
      expect_pulse(c + LAT, 4'b0000, 1'b0, 1'b1, 6'b100000);
      step(9);
      derecha_n = 1'b0;
      step(3);
      reset     = 1'b1;
      poner_raw = 1'b0;
      #1;
      chk("t6_rst_held", {26'd0, held}, 32'd0);
      chk("t6_rst_pulses", {26'd0, move_pulse, attack_pulse, poner_pulse}, 32'd0);
      step(2);
      reset = 1'b0;
      c = cyc;
      expect_pulse(c + LAT, 4'b0010, 1'b0, 1'b0, 6'b000010);
      step(12);
      @(negedge clk);
      chk("t6_held", {26'd0, held}, 32'd2);
      step(1);
      derecha_n = 1'b1;
      step(15);
      @(negedge clk);
      chk("final_held", {26'd0, held}, 32'd0);

      while (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missing_pulse got none expected move=%b att=%b pon=%b at cyc=%0d",
                  e.mv, e.at, e.po, e.cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
